// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-first bypass and hardwired x0.
// Define REGFILE_SCOREBOARD_EN to add per-register pending bits that stall reads.

module regfile_mp_rdport #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_W-1:0]              addr,
    input  logic                           addr_valid,
    input  logic [NUM_REGS-1:0][XLEN-1:0]  regs,
    input  logic [NUM_REGS-1:0]            pending,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [XLEN-1:0]                wr_data,
    output logic [XLEN-1:0]                data,
    output logic                           data_valid
);
    logic            hit_wr;
    logic            accept;
    logic [XLEN-1:0] rd_val;

    assign hit_wr = wr_en && (wr_addr == addr);

    // A pending register becomes readable on the same edge its writeback lands.
    assign accept = addr_valid && !(pending[addr] && !hit_wr);

    always_comb begin
        rd_val = regs[addr];
        if (hit_wr)
            rd_val = wr_data;
        if (addr == '0)
            rd_val = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid <= 1'b0;
            data       <= '0;
        end else begin
            data_valid <= accept;
            if (accept)
                data <= rd_val;
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_RD_PORTS   = 2,
    localparam int ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD_PORTS-1:0]        rd_addr_valid,
    output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]        rd_data_valid,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [XLEN-1:0]                wr_data,
    input  logic                           wr_en,
    output logic                           wr_ack,
    input  logic [ADDR_W-1:0]              rsv_addr,
    input  logic                           rsv_valid
);
    logic [NUM_REGS-1:0][XLEN-1:0] regs;
    logic [NUM_REGS-1:0]           pending;

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs   <= '0;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_en;
            if (wr_en && (wr_addr != '0))
                regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    // Reservation is applied after the clear so a new producer wins on a same-edge collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (wr_en)
                pending[wr_addr] <= 1'b0;
            if (rsv_valid && (rsv_addr != '0))
                pending[rsv_addr] <= 1'b1;
        end
    end
`else
    logic unused_rsv;
    assign pending    = '0;
    assign unused_rsv = ^{rsv_addr, rsv_valid};
`endif

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        regfile_mp_rdport #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) u_port (
            .clk        (clk),
            .reset      (reset),
            .addr       (rd_addr[p*ADDR_W +: ADDR_W]),
            .addr_valid (rd_addr_valid[p]),
            .regs       (regs),
            .pending    (pending),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .data       (rd_data[p*XLEN +: XLEN]),
            .data_valid (rd_data_valid[p])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp; scoreboard vectors run when REGFILE_SCOREBOARD_EN is defined.

module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int NP   = 2;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP-1:0]     rd_addr_valid;
    logic [NP*XLEN-1:0] rd_data;
    logic [NP-1:0]     rd_data_valid;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              wr_en;
    logic              wr_ack;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_valid;

    int nvec = 0;
    int nmis = 0;

    regfile_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_addr_valid (rd_addr_valid),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .wr_ack        (wr_ack),
        .rsv_addr      (rsv_addr),
        .rsv_valid     (rsv_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_addr_valid = '0;
        wr_en         = 1'b0;
        rsv_valid     = 1'b0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
        rd_addr_valid[p]    = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
    endtask

    function automatic logic [XLEN-1:0] pd(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        reset    = 1'b1;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();

        // Requests and a write presented during reset must be dropped.
        rd(0, 5'd5);
        rd(1, 5'd5);
        wr(5'd5, 32'h77);
        step();
        chk("rst_vld_1", rd_data_valid, 2'b00);
        step();
        step();
        chk("rst_vld_3", rd_data_valid, 2'b00);
        chk("rst_ack", wr_ack, 1'b0);
        chk("rst_data", rd_data, '0);
        reset = 1'b0;
        idle();

        rd(0, 5'd5);
        rd(1, 5'd5);
        step();
        chk("post_rst_vld", rd_data_valid, 2'b11);
        chk("post_rst_x5_p0", pd(0), 32'h0);
        chk("post_rst_x5_p1", pd(1), 32'h0);
        chk("post_rst_wack", wr_ack, 1'b0);

        idle();
        wr(5'd5, 32'h0000_002B);
        step();
        chk("wr_x5_ack", wr_ack, 1'b1);
        idle();
        rd(0, 5'd5);
        step();
        chk("rd_x5_vld", rd_data_valid, 2'b01);
        chk("rd_x5_data", pd(0), 32'h0000_002B);
        chk("wack_drop", wr_ack, 1'b0);

        // Same-edge write and read on both ports: write-first bypass.
        idle();
        wr(5'd7, 32'hDEAD_BEEF);
        rd(0, 5'd7);
        rd(1, 5'd7);
        step();
        chk("byp_vld", rd_data_valid, 2'b11);
        chk("byp_p0", pd(0), 32'hDEAD_BEEF);
        chk("byp_p1", pd(1), 32'hDEAD_BEEF);

        // x0 write is acked but discarded, even under bypass.
        idle();
        wr(5'd0, 32'hFFFF_FFFF);
        rd(0, 5'd0);
        step();
        chk("x0_wack", wr_ack, 1'b1);
        chk("x0_byp", pd(0), 32'h0);
        idle();
        rd(0, 5'd0);
        rd(1, 5'd0);
        step();
        chk("x0_rd_p0", pd(0), 32'h0);
        chk("x0_rd_p1", pd(1), 32'h0);

        // Preload x1..x3 then stream them on port 0.
        for (int i = 1; i <= 3; i++) begin
            idle();
            wr(AW'(i), XLEN'(i));
            step();
        end
        idle();
        for (int i = 1; i <= 3; i++) begin
            rd(0, AW'(i));
            step();
            chk($sformatf("strm_vld_%0d", i), rd_data_valid, 2'b01);
            chk($sformatf("strm_data_%0d", i), pd(0), 64'(i));
        end
        idle();
        step();
        chk("hold_vld", rd_data_valid, 2'b00);
        chk("hold_p0", pd(0), 32'h3);
        chk("hold_p1", pd(1), 32'h0);

        // Ports are independent: different addresses in one cycle.
        rd(0, 5'd7);
        rd(1, 5'd2);
        step();
        chk("ind_p0", pd(0), 32'hDEAD_BEEF);
        chk("ind_p1", pd(1), 32'h2);

        idle();
        wr(5'd4, 32'h44);
        step();
        idle();
        rsv_addr  = 5'd9;
        rsv_valid = 1'b1;
        step();
        idle();

`ifdef REGFILE_SCOREBOARD_EN
        for (int c = 0; c < 4; c++) begin
            rd(0, 5'd9);
            rd(1, 5'd4);
            step();
            chk($sformatf("sb_stall_vld_%0d", c), rd_data_valid, 2'b10);
            chk($sformatf("sb_p1_%0d", c), pd(1), 32'h44);
        end
        wr(5'd9, 32'h55);
        step();
        chk("sb_rel_vld", rd_data_valid, 2'b11);
        chk("sb_rel_data", pd(0), 32'h55);
        idle();
        rd(0, 5'd9);
        step();
        chk("sb_after_vld", rd_data_valid, 2'b01);
        chk("sb_after_data", pd(0), 32'h55);
`else
        // Without the scoreboard a reservation has no effect.
        rd(0, 5'd9);
        rd(1, 5'd4);
        step();
        chk("nosb_vld", rd_data_valid, 2'b11);
        chk("nosb_p0", pd(0), 32'h0);
        chk("nosb_p1", pd(1), 32'h44);
`endif

        // Reset mid-request clears valid on the sampling edge.
        idle();
        rd(0, 5'd4);
        reset = 1'b1;
        step();
        chk("midrst_vld", rd_data_valid, 2'b00);
        chk("midrst_data", pd(0), 32'h0);
        reset = 1'b0;
        idle();
        rd(0, 5'd4);
        step();
        chk("midrst_x4_cleared", pd(0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RISC-V core.
- Successor to the fixed two-port regfile feeding the R-type instruction handler operands A/B.
- Adds N read ports with a valid/ack handshake, write-to-read bypass, and hardwired x0.
- Optional scoreboard stalls reads of registers awaiting writeback.

Parameters:
XLEN, 32, data width of each register.
NUM_REGS, 32, register count; power of two, >= 2.
NUM_RD_PORTS, 2, number of independent read ports; 1..4.
ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
clk  input  1  core clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
rd_addr  input  NUM_RD_PORTS*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W].
rd_addr_valid  input  NUM_RD_PORTS  per-port read request.
rd_data  output  NUM_RD_PORTS*XLEN  read data, port p at bits [p*XLEN +: XLEN].
rd_data_valid  output  NUM_RD_PORTS  per-port read ack; 1-cycle pulse per accepted request.
wr_addr  input  ADDR_W  write address.
wr_data  input  XLEN  write data.
wr_en  input  1  write strobe.
wr_ack  output  1  write accepted; registered, 1 cycle after wr_en.
rsv_addr  input  ADDR_W  destination to reserve (scoreboard only; ignored otherwise).
rsv_valid  input  1  reserve strobe (scoreboard only; ignored otherwise).

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset, sampled high on an edge:
  - all registers, rd_data, rd_data_valid and wr_ack clear to 0 that edge;
  - pending bits clear;
  - requests and writes presented during reset are dropped, never acked.
- Reset mid-request: rd_data_valid is 0 on the edge after reset is sampled. The requester must re-issue.
- Read (per port, independent):
  - rd_addr_valid high at edge N is accepted at N;
  - at edge N+1, rd_data_valid=1 and rd_data=register value;
  - rd_data holds its value until the next accepted request.
- Back-to-back reads: rd_addr_valid held high gives one ack per cycle, with data tracking the address sampled each cycle.
- Bypass: a write at edge N to the same address as a read accepted at N returns wr_data (write-first).
- Multiple ports reading the same address in one cycle all receive identical data.
- x0:
  - reads always return 0, including under bypass;
  - writes to x0 are discarded but still acked (wr_ack=1 next cycle).
- Write: wr_en at edge N updates the register at N. The value is visible to reads accepted at N (bypass) and later.
- No read-port arbitration. All ports are served in the same cycle.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined: one pending bit per register.
  - rsv_valid at edge N sets pending[rsv_addr]; rsv_addr=0 is ignored.
  - wr_en at edge N clears pending[wr_addr].
  - Same edge, same address for rsv_valid and wr_en: write data is stored and pending ends set (reservation wins; a new producer follows an old writeback).
  - A read request to a pending register is not accepted: no rd_data_valid, and the requester holds rd_addr_valid.
  - Accept occurs at the edge where the bit clears. The bypass delivers the writing data with rd_data_valid at the following edge.
  - Pending is evaluated per port; other ports proceed.
- Undefined: rsv_addr/rsv_valid ignored, no pending state; every read is accepted in 1 cycle.

Test Plan:
- Reset held 3 cycles, then release → rd_data_valid=0, wr_ack=0, all reads return 0 after release.
- Write x5=0x0000_002B at edge N; port0 reads x5 at N+1 → ack at N+2 with 0x0000_002B; wr_ack=1 at N+1.
- Write x7=0xDEAD_BEEF and read x7 on both ports at the same edge → both ports ack next cycle with 0xDEAD_BEEF (bypass).
- Write x0=0xFFFF_FFFF, then read x0 → wr_ack=1; read returns 0x0000_0000.
- Port0 streams x1,x2,x3 on consecutive cycles, pre-loaded with 1,2,3 → three consecutive acks with data 1,2,3.
- Scoreboard build: reserve x9, read x9 for 4 cycles → no ack; write x9=0x55 → ack the next cycle with 0x55; port1 reading x4 meanwhile acks every cycle.
